// File: rtl/bist_controller.sv
// LFSR/MISR built-in self-test sequencer for the small gate-level top netlist.
// Owns the block's inputs and reset while a run is in progress.
module bist_controller #(
    parameter int                PATTERNS  = 64,
    parameter int                LFSR_W    = 8,
    parameter logic [LFSR_W-1:0] LFSR_SEED = LFSR_W'('h01),
    parameter logic [LFSR_W-1:0] LFSR_TAPS = LFSR_W'('hB8),
    parameter int                MISR_W    = 8,
    parameter logic [MISR_W-1:0] MISR_TAPS = MISR_W'('hB8),
    parameter logic [MISR_W-1:0] GOLDEN    = MISR_W'('h00)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [MISR_W-1:0] signature,
    output logic              dut_reset,
    output logic              dut_i1,
    output logic              dut_i2,
    input  logic              dut_o1,
    input  logic              dut_o2
);

    localparam int CW = $clog2(PATTERNS + 1);
    localparam logic [CW-1:0] LAST = CW'(PATTERNS - 1);
    localparam logic [LFSR_W-1:0] ONE = LFSR_W'(1);
    // An all-zero LFSR would lock up, so a zero seed loads 1 instead.
    localparam logic [LFSR_W-1:0] SEED = (LFSR_SEED == '0) ? ONE : LFSR_SEED;

    typedef enum logic [1:0] {
        S_IDLE,
        S_INIT,
        S_APPLY,
        S_COMPARE
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [LFSR_W-1:0] r_lfsr;
    logic [MISR_W-1:0] r_misr;
    logic [CW-1:0]     r_cnt;
    logic              r_pass;
    logic [MISR_W-1:0] r_sig;
    logic [LFSR_W-1:0] w_lfsr_nxt;
    logic [MISR_W-1:0] w_misr_nxt;
    logic              w_abort;

    assign w_abort    = abort && (r_state != S_IDLE);
    assign w_lfsr_nxt = {r_lfsr[LFSR_W-2:0], ^(r_lfsr & LFSR_TAPS)};
    assign w_misr_nxt = {r_misr[MISR_W-2:0], ^(r_misr & MISR_TAPS)}
                      ^ MISR_W'({dut_o2, dut_o1});

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_lfsr  <= '0;
            r_misr  <= '0;
            r_cnt   <= '0;
            r_pass  <= 1'b0;
            r_sig   <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_INIT: begin
                    r_lfsr <= SEED;
                    r_misr <= '0;
                    r_cnt  <= '0;
                end
                S_APPLY: begin
                    r_lfsr <= w_lfsr_nxt;
                    r_misr <= w_misr_nxt;
                    r_cnt  <= r_cnt + CW'(1);
                end
                S_COMPARE: begin
                    if (!abort) begin
                        r_sig  <= r_misr;
                        r_pass <= (r_misr == GOLDEN);
                    end
                end
                default: ;
            endcase
            if (w_abort) begin
                r_pass <= 1'b0;
            end
        end
    end

    always_comb begin
        w_next    = r_state;
        busy      = (r_state != S_IDLE);
        done      = 1'b0;
        dut_reset = reset;
        dut_i1    = 1'b0;
        dut_i2    = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (start) w_next = S_INIT;
            end
            S_INIT: begin
                dut_reset = 1'b1;
                w_next    = S_APPLY;
            end
            S_APPLY: begin
                dut_i1 = r_lfsr[0];
                dut_i2 = r_lfsr[1];
                if (r_cnt == LAST) w_next = S_COMPARE;
            end
            S_COMPARE: begin
                done   = !abort;
                w_next = S_IDLE;
            end
        endcase
        if (w_abort) w_next = S_IDLE;
    end

    assign pass      = r_pass;
    assign signature = r_sig;

endmodule

// File: tb/tb_bist_controller.sv
// Bench for bist_controller: two 4-pattern instances (golden 00 / 0F) and a
// 37-pattern zero-seed instance, compared against a plain-arithmetic model.
module tb_bist_controller;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic start_c = 1'b0;
    logic abort_c = 1'b0;
    int   mode = 0;
    logic c1 = 1'b0;
    logic c2 = 1'b0;
    int   checks = 0;
    int   errors = 0;

    logic busy_a, done_a, pass_a, rst_a, ia1, ia2, oa1, oa2;
    logic busy_b, done_b, pass_b, rst_b, ib1, ib2, ob1, ob2;
    logic busy_c, done_c, pass_c, rst_c, ic1, ic2, oc1, oc2;
    logic [7:0] sig_a, sig_b, sig_c;

    always #5 clock = ~clock;

    // Block-under-test stand-in; returns {o2, o1}.
    function automatic logic [1:0] stub(input int md, input logic i1,
                                        input logic i2, input logic k1,
                                        input logic k2);
        case (md)
            0:       return {k2, k1};
            1:       return {i2, i1};
            2:       return {i2 ^ k2, i1 ^ k1};
            default: return {i1 ^ k2, i2};
        endcase
    endfunction

    assign {oa2, oa1} = stub(mode, ia1, ia2, c1, c2);
    assign {ob2, ob1} = stub(mode, ib1, ib2, c1, c2);
    assign {oc2, oc1} = stub(mode, ic1, ic2, c1, c2);

    bist_controller #(.PATTERNS(4), .GOLDEN(8'h00)) u_a (
        .clock(clock), .reset(reset), .start(start), .abort(abort),
        .busy(busy_a), .done(done_a), .pass(pass_a), .signature(sig_a),
        .dut_reset(rst_a), .dut_i1(ia1), .dut_i2(ia2),
        .dut_o1(oa1), .dut_o2(oa2));

    bist_controller #(.PATTERNS(4), .GOLDEN(8'h0F)) u_b (
        .clock(clock), .reset(reset), .start(start), .abort(abort),
        .busy(busy_b), .done(done_b), .pass(pass_b), .signature(sig_b),
        .dut_reset(rst_b), .dut_i1(ib1), .dut_i2(ib2),
        .dut_o1(ob1), .dut_o2(ob2));

    bist_controller #(.PATTERNS(37), .LFSR_SEED(8'h00),
                      .GOLDEN(8'h5C)) u_c (
        .clock(clock), .reset(reset), .start(start_c), .abort(abort_c),
        .busy(busy_c), .done(done_c), .pass(pass_c), .signature(sig_c),
        .dut_reset(rst_c), .dut_i1(ic1), .dut_i2(ic2),
        .dut_o1(oc1), .dut_o2(oc2));

    function automatic logic [7:0] step(input logic [7:0] v);
        return (v << 1) | 8'($countones(v & 8'hB8) % 2);
    endfunction

    function automatic logic [1:0] model_vec(input int n,
                                             input logic [7:0] seed);
        logic [7:0] l;
        l = (seed == 8'h00) ? 8'h01 : seed;
        for (int j = 0; j < n; j++) l = step(l);
        return {l[1], l[0]};
    endfunction

    function automatic logic [7:0] model_sig(input int p,
                                             input logic [7:0] seed,
                                             input int md, input logic k1,
                                             input logic k2);
        logic [7:0] l;
        logic [7:0] m;
        l = (seed == 8'h00) ? 8'h01 : seed;
        m = 8'h00;
        for (int j = 0; j < p; j++) begin
            m = step(m) ^ {6'b0, stub(md, l[0], l[1], k1, k2)};
            l = step(l);
        end
        return m;
    endfunction

    task automatic cyc;
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic run_ab(input string tag, input int md, input logic k1,
                          input logic k2);
        logic [7:0] es;
        logic [1:0] v;
        mode = md; c1 = k1; c2 = k2;
        es = model_sig(4, 8'h01, md, k1, k2);
        @(posedge clock); #1 start = 1'b1;
        @(posedge clock); #1 start = 1'b0;
        @(negedge clock);
        checks++;
        if ({busy_a, busy_b, rst_a, done_a, ia1, ia2} !== 6'b111000) begin
            errors++;
            $display("FAIL %s init: busy/rst/done/i=%b want 111000", tag,
                     {busy_a, busy_b, rst_a, done_a, ia1, ia2});
        end
        for (int n = 0; n < 4; n++) begin
            cyc();
            v = model_vec(n, 8'h01);
            checks++;
            if ({ia2, ia1, ib2, ib1, done_a, rst_a} !== {v, v, 2'b00}) begin
                errors++;
                $display("FAIL %s vec%0d: got %b want %b", tag, n,
                         {ia2, ia1, ib2, ib1, done_a, rst_a}, {v, v, 2'b00});
            end
        end
        cyc();
        checks++;
        if ({done_a, done_b, busy_a} !== 3'b111) begin
            errors++;
            $display("FAIL %s done: got %b want 111", tag,
                     {done_a, done_b, busy_a});
        end
        cyc();
        checks++;
        if (sig_a !== es || sig_b !== es) begin
            errors++;
            $display("FAIL %s sig: got %h/%h want %h", tag, sig_a, sig_b, es);
        end
        checks++;
        if ({pass_a, pass_b, busy_a, done_a} !==
            {es == 8'h00, es == 8'h0F, 2'b00}) begin
            errors++;
            $display("FAIL %s pass: got %b want %b", tag,
                     {pass_a, pass_b, busy_a, done_a},
                     {es == 8'h00, es == 8'h0F, 2'b00});
        end
    endtask

    task automatic test_reset;
        for (int n = 0; n < 3; n++) begin
            cyc();
            checks++;
            if ({busy_a, done_a, pass_a, ia1, ia2, rst_a} !== 6'b000001 ||
                sig_a !== 8'h00) begin
                errors++;
                $display("FAIL reset%0d: flags %b sig %h want 000001 00", n,
                         {busy_a, done_a, pass_a, ia1, ia2, rst_a}, sig_a);
            end
        end
        @(posedge clock); #1 reset = 1'b0;
        @(negedge clock);
        checks++;
        if ({rst_a, rst_b, rst_c, busy_a, busy_c} !== 5'b00000) begin
            errors++;
            $display("FAIL reset_release: got %b want 00000",
                     {rst_a, rst_b, rst_c, busy_a, busy_c});
        end
    endtask

    task automatic test_vectors;
        run_ab("vec_const", 0, 1'b1, 1'b0);
        run_ab("vec_repeat", 0, 1'b1, 1'b0);
        run_ab("vec_echo", 1, 1'b0, 1'b0);
    endtask

    task automatic test_random;
        for (int r = 0; r < 6; r++) begin
            run_ab("rand", int'($urandom_range(0, 3)), 1'($urandom),
                   1'($urandom));
        end
    endtask

    task automatic test_abort;
        int dn;
        run_ab("pre_abort", 0, 1'b1, 1'b0);
        mode = 1;
        @(posedge clock); #1 start = 1'b1;
        @(posedge clock); #1 start = 1'b0;
        @(posedge clock);
        @(posedge clock); #1 abort = 1'b1;
        @(negedge clock);
        @(posedge clock); #1 abort = 1'b0;
        @(negedge clock);
        checks++;
        if ({busy_a, ia1, ia2, pass_b} !== 4'b0000 || sig_b !== 8'h0F) begin
            errors++;
            $display("FAIL abort_apply: flags %b sig %h want 0000 0f",
                     {busy_a, ia1, ia2, pass_b}, sig_b);
        end
        dn = 0;
        for (int n = 0; n < 8; n++) begin
            cyc();
            if (done_a || done_b) dn++;
        end
        checks++;
        if (dn != 0) begin
            errors++;
            $display("FAIL abort_nodone: got %0d pulses want 0", dn);
        end
        run_ab("pre_abort2", 0, 1'b1, 1'b0);
        mode = 1;
        @(posedge clock); #1 start = 1'b1;
        @(posedge clock); #1 start = 1'b0;
        repeat (4) @(posedge clock);
        @(posedge clock); #1 abort = 1'b1;
        @(negedge clock);
        checks++;
        if ({done_a, done_b, busy_a} !== 3'b001) begin
            errors++;
            $display("FAIL abort_compare: done/busy %b want 001",
                     {done_a, done_b, busy_a});
        end
        @(posedge clock); #1 abort = 1'b0;
        @(negedge clock);
        checks++;
        if ({pass_b, busy_b} !== 2'b00 || sig_b !== 8'h0F ||
            sig_a !== 8'h0F) begin
            errors++;
            $display("FAIL abort_compare_hold: %b sig %h/%h want 00 0f/0f",
                     {pass_b, busy_b}, sig_a, sig_b);
        end
        @(posedge clock); #1 start = 1'b1; abort = 1'b1;
        @(posedge clock); #1 start = 1'b0;
        @(negedge clock);
        checks++;
        if ({busy_a, rst_a} !== 2'b11) begin
            errors++;
            $display("FAIL start_beats_abort: busy/rst %b want 11",
                     {busy_a, rst_a});
        end
        @(posedge clock); #1 abort = 1'b0;
        @(negedge clock);
        checks++;
        if ({busy_a, rst_a, ia1} !== 3'b000) begin
            errors++;
            $display("FAIL abort_init: busy/rst/i1 %b want 000",
                     {busy_a, rst_a, ia1});
        end
    endtask

    task automatic test_start_while_busy;
        int dn;
        int at;
        mode = 0; c1 = 1'b1; c2 = 1'b0;
        @(posedge clock); #1 start = 1'b1;
        @(posedge clock); #1 start = 1'b0;
        @(negedge clock);
        dn = 0; at = -1;
        for (int n = 2; n <= 12; n++) begin
            @(posedge clock);
            if (n == 3) #1 start = 1'b1;
            if (n == 4) #1 start = 1'b0;
            @(negedge clock);
            if (done_a) begin
                dn++;
                at = n;
            end
        end
        checks++;
        if (dn != 1 || at != 6) begin
            errors++;
            $display("FAIL start_busy: %0d pulses at k+%0d want 1 at k+6",
                     dn, at);
        end
        checks++;
        if (sig_a !== 8'h0F) begin
            errors++;
            $display("FAIL start_busy_sig: got %h want 0f", sig_a);
        end
    endtask

    task automatic test_reset_mid_run;
        mode = 1;
        @(posedge clock); #1 start = 1'b1;
        @(posedge clock); #1 start = 1'b0;
        @(posedge clock);
        @(posedge clock); #1 reset = 1'b1;
        @(negedge clock);
        checks++;
        if ({rst_a, rst_b} !== 2'b11) begin
            errors++;
            $display("FAIL mid_reset_out: got %b want 11", {rst_a, rst_b});
        end
        @(posedge clock); #1 reset = 1'b0;
        @(negedge clock);
        checks++;
        if ({busy_a, done_a, pass_b, ia1, ia2, rst_a} !== 6'b000000 ||
            sig_b !== 8'h00) begin
            errors++;
            $display("FAIL mid_reset: flags %b sig %h want 000000 00",
                     {busy_a, done_a, pass_b, ia1, ia2, rst_a}, sig_b);
        end
        run_ab("after_reset", 0, 1'b1, 1'b0);
    endtask

    task automatic test_long_zero_seed;
        logic [7:0] es;
        int at;
        mode = int'($urandom_range(1, 3));
        c1 = 1'($urandom); c2 = 1'($urandom);
        es = model_sig(37, 8'h00, mode, c1, c2);
        @(posedge clock); #1 start_c = 1'b1;
        @(posedge clock); #1 start_c = 1'b0;
        @(negedge clock);
        at = -1;
        for (int n = 2; n < 100 && at < 0; n++) begin
            cyc();
            if (n == 2) begin
                checks++;
                if ({ic2, ic1} !== model_vec(0, 8'h00)) begin
                    errors++;
                    $display("FAIL zero_seed_vec: got %b want %b",
                             {ic2, ic1}, model_vec(0, 8'h00));
                end
            end
            if (done_c) at = n;
        end
        checks++;
        if (at != 39) begin
            errors++;
            $display("FAIL long_done: at k+%0d want k+39", at);
        end
        cyc();
        checks++;
        if (sig_c !== es || pass_c !== (es == 8'h5C)) begin
            errors++;
            $display("FAIL long_sig: got %h/%b want %h/%b", sig_c, pass_c,
                     es, es == 8'h5C);
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_random();
        test_abort();
        test_start_while_busy();
        test_reset_mid_run();
        test_long_zero_seed();
        repeat (2) @(posedge clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bist_controller.md
# bist_controller

Built-in self-test sequencer for the small gate-level `top` netlist (two inputs, two outputs, one resettable flop). On `start` it resets the block under test and drives `PATTERNS` pseudo-random input vectors from an LFSR. It compresses the block's outputs into a MISR signature and compares the result against a golden value. It sits beside the block under test and owns its inputs and its reset during a test run.

## Interface
Parameters:
- `PATTERNS`, 64: number of vectors applied per run; must be ≥ 1.
- `LFSR_W`, 8: LFSR width; must be ≥ 2.
- `LFSR_SEED`, 8'h01: LFSR load value at run start. A zero value is replaced by 1.
- `LFSR_TAPS`, 8'hB8: LFSR feedback mask.
- `MISR_W`, 8: MISR width; must be ≥ 2.
- `MISR_TAPS`, 8'hB8: MISR feedback mask.
- `GOLDEN`, 8'h00: expected signature.

Ports:
- `clock`  in  1  clock, rising edge.
- `reset`  in  1  reset, synchronous, active-high.
- `start`  in  1  begin a run; sampled only in IDLE.
- `abort`  in  1  cancel a run in progress.
- `busy`  out  1  high in INIT, APPLY and COMPARE.
- `done`  out  1  one-cycle pulse in COMPARE.
- `pass`  out  1  result of the last completed run; held.
- `signature`  out  MISR_W  final MISR value of the last completed run; held.
- `dut_reset`  out  1  reset to the block under test.
- `dut_i1`, `dut_i2`  out  1 each  stimulus.
- `dut_o1`, `dut_o2`  in  1 each  responses.

## Operation
States: IDLE, INIT, APPLY, COMPARE. State and all registers are synchronous.
- **IDLE:** `busy=0`, `dut_i1=dut_i2=0`. `start=1` moves to INIT.
- **INIT**, exactly 1 cycle:
  - `dut_reset=1`.
  - LFSR loads `LFSR_SEED`; MISR clears to 0; pattern counter clears to 0.
  - Moves to APPLY.
- **APPLY**, exactly `PATTERNS` cycles:
  - Drives `dut_i1=lfsr[0]` and `dut_i2=lfsr[1]` combinationally from the LFSR register.
  - Each cycle the LFSR steps: `lfsr <= {lfsr[W-2:0], ^(lfsr & LFSR_TAPS)}`.
  - Each cycle the MISR steps: `misr <= {misr[W-2:0], ^(misr & MISR_TAPS)} ^ {0…, dut_o2, dut_o1}`.
  - Responses are sampled in the same cycle as the vector is applied. The block under test's flop state from earlier vectors contributes through `dut_o1`.
  - Counter increments each cycle. When the counter reaches `PATTERNS-1` the next state is COMPARE.
  - Counter width is `$clog2(PATTERNS+1)`.
- **COMPARE**, 1 cycle:
  - `done=1`.
  - `signature <= misr` and `pass <= (misr == GOLDEN)`, both registered at the end of this cycle.
  - Moves to IDLE.
- **Stimulus outside APPLY:** `dut_i1=dut_i2=0`.
- **`dut_reset`:** `dut_reset = reset | (state == INIT)`.
- **`abort`:** in INIT, APPLY or COMPARE, moves to IDLE next cycle.
  - `done` is not pulsed.
  - `pass` clears to 0; `signature` is unchanged.
  - `abort` has priority over the COMPARE `done` pulse.
  - `abort` in IDLE has no effect.
- **`start` while busy:** ignored; it is not queued.
- **Simultaneous `start` and `abort` in IDLE:** `start` wins.

## Timing
- **Reset:** state is IDLE; `busy`, `done`, `pass`, `dut_i1` and `dut_i2` are 0; `signature` is 0; `dut_reset` is 1 while `reset` is high.
- **Reset mid-run:** the run is abandoned and all of the above values are reapplied on the next edge.
- **Run latency:** with `start` high in cycle k (IDLE):
  - INIT in cycle k+1.
  - APPLY in cycles k+2 … k+PATTERNS+1.
  - `done` in cycle k+PATTERNS+2.
  - `pass` and `signature` are valid from cycle k+PATTERNS+3.
- **Back-to-back runs:** a new `start` is accepted in the first IDLE cycle after COMPARE.
- **Reproducibility:** identical runs produce identical signatures because the seed is reloaded in INIT.
- **`busy`:** a registered decode of the state; high from k+1 through k+PATTERNS+2.

## Test plan
- **Reset values:** hold `reset` 3 cycles -> `busy=0`, `done=0`, `pass=0`, `signature=0`, `dut_i*=0`, `dut_reset=1`; after release `dut_reset=0`.
- **Vector sequence:** PATTERNS=4, defaults, stub `dut_o1=1`, `dut_o2=0`, `start` at cycle k -> (i1,i2) = (1,0),(0,1),(0,0),(0,0) in k+2..k+5; `done` at k+6; `signature=8'h0F`; `pass=0`.
- **Golden match:** same stimulus with GOLDEN=8'h0F -> `pass=1`; a second identical run gives `signature=8'h0F` again. With `dut_o1=dut_i1`, `dut_o2=dut_i2` and GOLDEN=8'h00 -> `signature=8'h00`, `pass=1`.
- **Abort:** assert `abort` in the 2nd APPLY cycle -> IDLE next cycle, no `done` pulse, `pass=0`, `signature` unchanged, `dut_i*=0`.
- **Start while busy:** pulse `start` during APPLY -> no restart; `done` still at k+6; exactly one `done` pulse.
- **Reset mid-run:** assert `reset` in APPLY -> IDLE with all reset values next cycle; a following `start` completes normally with `signature=8'h0F`.
